sprite_palette_arbiter: RTL

Shares one combinational 8-entry sprite palette (3-bit index in, 12-bit {R,G,B} out) among several sprite renderers. Each renderer issues palette-index lookups over a valid/ready handshake. The arbiter grants one requester per cycle in round-robin order, drives the granted index into the palette, and registers the returned colour with the requester's ID. It sits between the per-sprite renderers and the frame-buffer/VGA colour mux.

---
 rtl/sprite_palette_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sprite_palette_arbiter.sv
// Round-robin arbiter sharing one combinational sprite palette among NUM_REQ renderers.
// Optional hit-flash whitening is enabled by defining SPRITE_PALETTE_FLASH_EN.
module sprite_palette_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned FLASH_LEN = 16
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]   req_index,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [IDX_W-1:0]           pal_index,
  input  logic [11:0]                pal_rgb,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [IDX_W-1:0]           rsp_index,
  output logic [11:0]                rsp_rgb,
  input  logic                       rsp_ready,
  input  logic                       flash_trig
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0]   rsp_id_q, rsp_id_d;
  logic [IDX_W-1:0] rsp_index_q, rsp_index_d;
  logic [11:0]      rsp_rgb_q, rsp_rgb_d;

  logic             out_free;
  logic             gnt_found;
  logic             grant;
  logic [IdW-1:0]   gnt_id;
  logic [IdW-1:0]   cand;
  logic [11:0]      colour;

  assign out_free = !rsp_valid_q || rsp_ready;
  assign grant    = out_free && gnt_found;

  // Scan upward from rr_ptr, wrapping at NUM_REQ; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    pal_index = '0;
    if (grant) begin
      req_ready[gnt_id] = 1'b1;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (gnt_id == IdW'(k)) begin
          pal_index = req_index[k*IDX_W +: IDX_W];
        end
      end
    end
  end

`ifdef SPRITE_PALETTE_FLASH_EN
  localparam int unsigned FlashW = $clog2(FLASH_LEN + 1);

  logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;

  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (flash_trig) begin
      flash_cnt_d = FlashW'(FLASH_LEN);
    end else if (flash_cnt_q != '0) begin
      flash_cnt_d = flash_cnt_q - FlashW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flash_cnt_q <= '0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
    end
  end

  // Index 0 is the transparent key and must never be whitened.
  assign colour = ((flash_cnt_q != '0) && (pal_index != '0)) ? 12'hFFF : pal_rgb;
`else
  logic unused_flash;
  assign unused_flash = flash_trig ^ (FLASH_LEN == 0);
  assign colour       = pal_rgb;
`endif

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_index_d = rsp_index_q;
    rsp_rgb_d   = rsp_rgb_q;
    if (grant) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id;
      rsp_index_d = pal_index;
      rsp_rgb_d   = colour;
      rr_ptr_d    = (gnt_id == IdW'(NUM_REQ - 1)) ? '0 : gnt_id + IdW'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_index_q <= '0;
      rsp_rgb_q   <= 12'h000;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_index_q <= rsp_index_d;
      rsp_rgb_q   <= rsp_rgb_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_index = rsp_index_q;
  assign rsp_rgb   = rsp_rgb_q;

endmodule
